// File: rtl/inst_encode_pkg.sv
// Shared types and encoding constants for the RV64I instruction encoder.
// Counter outputs on the encoder appear only when INST_ENC_COUNT_EN is defined.
package inst_encode_pkg;

   localparam int ENC_XLEN = 64;

   typedef enum logic [3:0] {
      OP_ADD,
      OP_SUB,
      OP_AND,
      OP_OR,
      OP_XOR,
      OP_ADDI,
      OP_XORI,
      OP_ORI,
      OP_ANDI,
      OP_ADDIW,
      OP_ADDW,
      OP_SUBW,
      OP_LUI,
      OP_AUIPC
   } instruction_type;

   localparam logic [6:0] OPC_R     = 7'h33;
   localparam logic [6:0] OPC_RW    = 7'h3B;
   localparam logic [6:0] OPC_I     = 7'h13;
   localparam logic [6:0] OPC_IW    = 7'h1B;
   localparam logic [6:0] OPC_LUI   = 7'h37;
   localparam logic [6:0] OPC_AUIPC = 7'h17;

   localparam logic [2:0] F3_ADD = 3'd0;
   localparam logic [2:0] F3_XOR = 3'd4;
   localparam logic [2:0] F3_OR  = 3'd6;
   localparam logic [2:0] F3_AND = 3'd7;

   localparam logic [6:0] F7_BASE = 7'h00;
   localparam logic [6:0] F7_SUB  = 7'h20;

   typedef enum logic {
      IDLE,
      LI_SECOND
   } enc_state_t;

   typedef struct packed {
      instruction_type       op;
      logic                  li;
      logic [4:0]            rd;
      logic [4:0]            rs1;
      logic [4:0]            rs2;
      logic [ENC_XLEN-1:0]   imm;
   } enc_req_t;

   function automatic logic is_itype(
      input instruction_type op
   );
      return op inside {OP_ADDI, OP_XORI,
                        OP_ORI, OP_ANDI,
                        OP_ADDIW};
   endfunction

   function automatic logic is_utype(
      input instruction_type op
   );
      return op inside {OP_LUI, OP_AUIPC};
   endfunction

endpackage

// File: rtl/inst_pack.sv
// Combinational field packer: operation plus operands to a 32-bit RV64I word.
// Shared by the encoder for both request words and the deferred LI tail.
module inst_pack
   import inst_encode_pkg::*;
(
   input  instruction_type op,
   input  logic [4:0]      rd,
   input  logic [4:0]      rs1,
   input  logic [4:0]      rs2,
   input  logic [19:0]     imm,
   output logic [31:0]     word
);

   logic [11:0] imm_i;

   assign imm_i = imm[11:0];

   always_comb begin
      word = '0;
      case (op)
         OP_ADD:
            word = {F7_BASE, rs2, rs1,
                    F3_ADD, rd, OPC_R};
         OP_SUB:
            word = {F7_SUB, rs2, rs1,
                    F3_ADD, rd, OPC_R};
         OP_AND:
            word = {F7_BASE, rs2, rs1,
                    F3_AND, rd, OPC_R};
         OP_OR:
            word = {F7_BASE, rs2, rs1,
                    F3_OR, rd, OPC_R};
         OP_XOR:
            word = {F7_BASE, rs2, rs1,
                    F3_XOR, rd, OPC_R};
         OP_ADDW:
            word = {F7_BASE, rs2, rs1,
                    F3_ADD, rd, OPC_RW};
         OP_SUBW:
            word = {F7_SUB, rs2, rs1,
                    F3_ADD, rd, OPC_RW};
         OP_ADDI:
            word = {imm_i, rs1, F3_ADD,
                    rd, OPC_I};
         OP_XORI:
            word = {imm_i, rs1, F3_XOR,
                    rd, OPC_I};
         OP_ORI:
            word = {imm_i, rs1, F3_OR,
                    rd, OPC_I};
         OP_ANDI:
            word = {imm_i, rs1, F3_AND,
                    rd, OPC_I};
         OP_ADDIW:
            word = {imm_i, rs1, F3_ADD,
                    rd, OPC_IW};
         OP_LUI:
            word = {imm, rd, OPC_LUI};
         OP_AUIPC:
            word = {imm, rd, OPC_AUIPC};
         default:
            word = '0;
      endcase
   end

endmodule

// File: rtl/inst_encode.sv
// Request-to-word encoder with LI expansion and a one-word output register.
// INST_ENC_COUNT_EN adds words_emitted and err_count outputs.
module inst_encode
   import inst_encode_pkg::*;
#(
   parameter int XLEN = ENC_XLEN
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  instruction_type in_op,
   input  logic            in_li,
   input  logic [4:0]      in_rd,
   input  logic [4:0]      in_rs1,
   input  logic [4:0]      in_rs2,
   input  logic [XLEN-1:0] in_imm,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [31:0]     out_inst,
   output logic            out_last,
   output logic            err
`ifdef INST_ENC_COUNT_EN
   ,
   output logic [31:0]     words_emitted,
   output logic [15:0]     err_count
`endif
);

   enc_req_t        req;
   enc_state_t      state;
   enc_state_t      state_n;

   logic [31:0]     pend_inst;
   logic [31:0]     pend_n;
   logic            valid_n;
   logic [31:0]     inst_n;
   logic            last_n;
   logic            err_n;

   logic [31:0]     imm32;
   logic [11:0]     lo;
   logic [19:0]     hi;
   logic            i_ok;
   logic            u_ok;
   logic            li_ok;
   logic            bad;
   logic            two_word;
   logic            accept;
   logic            take;

   instruction_type p_op;
   logic [4:0]      p_rs1;
   logic [19:0]     p_imm;
   logic [31:0]     first_word;
   logic [31:0]     tail_word;

   always_comb begin
      req     = '0;
      req.op  = in_op;
      req.li  = in_li;
      req.rd  = in_rd;
      req.rs1 = in_rs1;
      req.rs2 = in_rs2;
      req.imm = in_imm;
   end

   // (imm + 0x800) >> 12 without a wide adder: carry in from imm[11]
   assign imm32 = req.imm[31:0];
   assign lo    = imm32[11:0];
   assign hi    = imm32[31:12]
                + {19'd0, imm32[11]};

   assign i_ok  = req.imm ==
      {{(ENC_XLEN-12){req.imm[11]}},
       req.imm[11:0]};
   assign u_ok  = req.imm[63:20] == '0;
   assign li_ok = req.imm ==
      {{(ENC_XLEN-32){req.imm[31]}},
       req.imm[31:0]};

   always_comb begin
      bad = 1'b0;
      if (req.li)
         bad = !li_ok;
      else if (is_itype(req.op))
         bad = !i_ok;
      else if (is_utype(req.op))
         bad = !u_ok;
   end

   assign two_word = req.li
                  && (hi != '0)
                  && (lo != '0);

   always_comb begin
      p_op  = req.op;
      p_rs1 = req.rs1;
      p_imm = req.imm[19:0];
      if (req.li) begin
         if (hi == '0) begin
            p_op  = OP_ADDI;
            p_rs1 = 5'd0;
            p_imm = {8'd0, lo};
         end else begin
            p_op  = OP_LUI;
            p_imm = hi;
         end
      end
   end

   inst_pack u_first (
      .op   (p_op),
      .rd   (req.rd),
      .rs1  (p_rs1),
      .rs2  (req.rs2),
      .imm  (p_imm),
      .word (first_word)
   );

   // ADDIW keeps the 0x80000 upper half sign-correct on RV64
   inst_pack u_tail (
      .op   (OP_ADDIW),
      .rd   (req.rd),
      .rs1  (req.rd),
      .rs2  (5'd0),
      .imm  ({8'd0, lo}),
      .word (tail_word)
   );

   assign in_ready = (state == IDLE)
                  && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;
   assign take     = out_valid && out_ready;

   always_comb begin
      state_n = state;
      valid_n = out_valid;
      inst_n  = out_inst;
      last_n  = out_last;
      pend_n  = pend_inst;
      err_n   = 1'b0;
      unique case (state)
         LI_SECOND: begin
            if (take) begin
               inst_n  = pend_inst;
               last_n  = 1'b1;
               pend_n  = '0;
               state_n = IDLE;
            end
         end
         default: begin
            if (take)
               valid_n = 1'b0;
            if (accept) begin
               if (bad) begin
                  err_n = 1'b1;
               end else begin
                  valid_n = 1'b1;
                  inst_n  = first_word;
                  last_n  = !two_word;
                  if (two_word) begin
                     pend_n  = tail_word;
                     state_n = LI_SECOND;
                  end
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         out_inst  <= '0;
         out_last  <= 1'b0;
         err       <= 1'b0;
         pend_inst <= '0;
      end else begin
         state     <= state_n;
         out_valid <= valid_n;
         out_inst  <= inst_n;
         out_last  <= last_n;
         err       <= err_n;
         pend_inst <= pend_n;
      end
   end

`ifdef INST_ENC_COUNT_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         words_emitted <= '0;
         err_count     <= '0;
      end else begin
         if (take)
            words_emitted <= words_emitted + 32'd1;
         if (err && (err_count != 16'hFFFF))
            err_count <= err_count + 16'd1;
      end
   end
`endif

endmodule
